// File: rtl/led_pattern_pkg.sv
// Shared types and defaults for the multi-channel LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    // Clock cycles per tick: 1 ms at a 50 MHz board clock.
    localparam int DEFAULT_PRESCALE = 50000;

endpackage

// File: rtl/blink_channel.sv
// One LED channel: config registers, tick-driven phase counter and a registered output.
module blink_channel
    import led_pattern_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             restart,
    input  logic             we,
    input  mode_t            mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] on,
    output logic             blink
);

    mode_t            mode_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] on_q;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] last_phase;

    // A zero period behaves as a one-tick period, so the last phase is 0.
    always_comb last_phase = (period_q == '0) ? '0 : period_q - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            period_q <= '0;
            on_q     <= '0;
            phase_q  <= '0;
            blink    <= 1'b0;
        end else begin
            // NOTE: the write branch is tested first so a config write always wins over a same-cycle tick.
            if (we) begin
                mode_q   <= mode;
                period_q <= period;
                on_q     <= on;
                phase_q  <= '0;
            end else if (restart) begin
                phase_q <= '0;
            end else if (tick) begin
                case (mode_q)
                    MODE_BLINK:   phase_q <= (phase_q >= last_phase) ? '0 : phase_q + CNT_W'(1);
                    MODE_ONESHOT: if (phase_q < on_q) phase_q <= phase_q + CNT_W'(1);
                    default:      phase_q <= '0;
                endcase
            end

            case (mode_q)
                MODE_OFF: blink <= 1'b0;
                MODE_ON:  blink <= 1'b1;
                default:  blink <= (phase_q < on_q);
            endcase
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, config write decode
// and one blink_channel per LED output.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 10,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_on,
    input  logic                restart,
    output logic                tick,
    output logic [CHANNELS-1:0] blink
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
            tick   <= 1'b1;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
            tick   <= 1'b0;
        end
    end

    // Addresses at or above CHANNELS match no channel, so those writes are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic ch_we;
        assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

        blink_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .restart(restart),
            .we     (ch_we),
            .mode   (mode_t'(cfg_mode)),
            .period (cfg_period),
            .on     (cfg_on),
            .blink  (blink[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (PRESCALE=4, CNT_W=4): stimulus queues
// cycle-stamped expectations of {tick, blink}; a negedge monitor pops and compares.
module tb_led_pattern_gen;

    localparam logic [4:0] ALL  = 5'b11111;
    localparam logic [4:0] LEDS = 5'b01111;
    localparam logic [4:0] TK   = 5'b10000;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_period;
    logic [3:0] cfg_on;
    logic       restart;
    logic       tick;
    logic [3:0] blink;

    led_pattern_gen #(
        .PRESCALE(4),
        .CHANNELS(4),
        .CNT_W   (4),
        .CH_W    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_period(cfg_period),
        .cfg_on    (cfg_on),
        .restart   (restart),
        .tick      (tick),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; expectations are stamped with it.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  mask;
        logic [4:0]  val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic expect_at(input int unsigned c, input logic [4:0] mask,
                             input logic [4:0] val, input string name);
        exp_t e;
        int   pos;
        e   = '{cyc: c, mask: mask, val: val, name: name};
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [4:0] obs;
        obs = {tick, blink};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: sampled at cycle %0d, required at cycle %0d", e.name, cyc, e.cyc);
            end else if ((obs & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: cycle %0d {tick,blink}=%b, expected %b (mask %b)",
                         e.name, cyc, obs, e.val, e.mask);
            end
        end
        if (done || cyc > 2000) begin
            checks++;
            if (!done || sb.size() != 0) begin
                errors++;
                $display("FAIL drain: done=%0d, %0d expectations left at cycle %0d, expected 0",
                         done, sb.size(), cyc);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic cyc_wait(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Applies one config write (optionally with restart) on the next rising edge.
    task automatic write(input int ch, input int mode, input int per, input int on, input bit rs);
        cfg_ch     = 2'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = 4'(per);
        cfg_on     = 4'(on);
        cfg_we     = 1'b1;
        restart    = rs;
        @(negedge clk);
        cfg_we  = 1'b0;
        restart = 1'b0;
    endtask

    initial begin : stimulus
        int unsigned r;
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_period = '0; cfg_on = '0; restart = 1'b0;

        // Reset: last reset edge is 3, so ticks appear 4, 8 edges later.
        expect_at(2,  ALL, 5'b00000, "reset_hold");
        expect_at(3,  ALL, 5'b00000, "reset_end");
        expect_at(4,  ALL, 5'b00000, "no_tick_1");
        expect_at(6,  ALL, 5'b00000, "no_tick_3");
        expect_at(7,  ALL, 5'b10000, "first_tick");
        expect_at(8,  ALL, 5'b00000, "tick_one_cycle");
        expect_at(11, ALL, 5'b10000, "second_tick");
        cyc_wait(3);
        rst = 1'b0;

        // BLINK ch0 period 5 on 2, aligned by a coincident restart.
        cyc_wait(12);
        r = cyc + 1;
        expect_at(r + 1,  ALL, 5'b00001, "blink_first_on");
        expect_at(r + 9,  ALL, 5'b00001, "blink_last_on");
        expect_at(r + 10, ALL, 5'b00000, "blink_first_off");
        expect_at(r + 21, ALL, 5'b00000, "blink_last_off");
        expect_at(r + 22, ALL, 5'b00001, "blink_cycle2_on");
        expect_at(r + 29, ALL, 5'b00001, "blink_high_8cyc");
        expect_at(r + 30, ALL, 5'b00000, "blink_cycle2_off");
        expect_at(r + 41, ALL, 5'b00000, "blink_low_12cyc");
        expect_at(r + 42, ALL, 5'b00001, "blink_cycle3_on");
        write(0, 2, 5, 2, 1'b1);
        cyc_wait(r + 42);

        // Boundaries: ch0 OFF, ch1 on>=period, ch2 zero/zero, ch3 ON.
        r = cyc + 4;
        expect_at(r + 1,  LEDS, 5'b01010, "bound_first");
        expect_at(r + 10, LEDS, 5'b01010, "bound_mid");
        expect_at(r + 30, LEDS, 5'b01010, "bound_late");
        write(0, 0, 0, 0, 1'b0);
        write(1, 2, 3, 3, 1'b0);
        write(2, 2, 0, 0, 1'b0);
        write(3, 1, 0, 0, 1'b0);
        cyc_wait(r + 30);

        // ONESHOT ch0 on 3, then retrigger with the same config.
        r = cyc + 1;
        expect_at(r + 1,  ALL, 5'b01011, "oneshot_start");
        expect_at(r + 13, ALL, 5'b01011, "oneshot_last_on");
        expect_at(r + 14, ALL, 5'b01010, "oneshot_off");
        expect_at(r + 40, ALL, 5'b11010, "oneshot_stays_off");
        expect_at(r + 43, ALL, 5'b01011, "retrigger_on");
        expect_at(r + 53, ALL, 5'b01011, "retrigger_last_on");
        expect_at(r + 54, ALL, 5'b01010, "retrigger_off");
        write(0, 3, 0, 3, 1'b1);
        cyc_wait(r + 41);
        write(0, 3, 0, 3, 1'b0);
        cyc_wait(r + 54);

        // Period 8 at phase 6, rewritten to period 4 on 1 on a tick edge.
        r = cyc + 1;
        expect_at(r + 9,  ALL, 5'b01011, "p8_phase1");
        expect_at(r + 10, ALL, 5'b01010, "p8_phase2");
        expect_at(r + 27, ALL, 5'b01010, "p8_phase6");
        expect_at(r + 30, ALL, 5'b01011, "collide_phase0");
        expect_at(r + 33, ALL, 5'b01011, "collide_on_end");
        expect_at(r + 34, ALL, 5'b01010, "collide_off");
        expect_at(r + 45, ALL, 5'b01010, "p4_last_off");
        expect_at(r + 46, ALL, 5'b01011, "p4_wrap_on");
        expect_at(r + 49, ALL, 5'b01011, "p4_on_end");
        expect_at(r + 50, ALL, 5'b01010, "p4_off_again");
        write(0, 2, 8, 2, 1'b1);
        cyc_wait(r + 28);
        write(0, 2, 4, 1, 1'b0);
        cyc_wait(r + 50);

        // Two channels at different phases, then restart on a would-be tick edge.
        expect_at(r + 63, ALL, 5'b01010, "pre_restart_skew");
        r = r + 64;
        expect_at(r,      TK,  5'b00000, "restart_no_tick");
        expect_at(r + 1,  ALL, 5'b01011, "lock_on");
        expect_at(r + 4,  TK,  5'b10000, "restart_tick");
        expect_at(r + 9,  ALL, 5'b01011, "lock_on_end");
        expect_at(r + 10, ALL, 5'b01000, "lock_off");
        expect_at(r + 17, ALL, 5'b01000, "lock_off_end");
        expect_at(r + 18, ALL, 5'b01011, "lock_on_again");
        expect_at(r + 26, ALL, 5'b01000, "lock_off_again");
        cyc_wait(r - 13);
        write(0, 2, 4, 2, 1'b0);
        cyc_wait(r - 7);
        write(1, 2, 4, 2, 1'b0);
        cyc_wait(r - 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        cyc_wait(r + 26);

        // rst mid-pattern, coinciding with a write and a restart.
        r = cyc + 1;
        expect_at(r,      ALL,  5'b00000, "rst_clears");
        expect_at(r + 3,  ALL,  5'b00000, "rst_modes_off");
        expect_at(r + 4,  ALL,  5'b10000, "rst_tick_realign");
        expect_at(r + 10, LEDS, 5'b00000, "rst_stays_off");
        rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'd1; restart = 1'b1;
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b0; restart = 1'b0;
        cyc_wait(r + 11);
        done = 1'b1;
    end

endmodule
